dmem_lsu: RTL and testbench

//  Load/store unit between the CPU datapath and the word-wide data RAM (sync read, sync write).

---
 rtl/dmem_lsu.sv | 181 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU datapath and a word-wide synchronous data RAM.
// Handles byte/half/word loads and stores, with sub-word stores done by read-modify-write.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for req; latches the request and checks it for faults
// RD    | RAM read issued, ram_rdata not yet valid
// CAP   | ram_rdata valid; extract and extend the load lane into rdata
// MRG   | ram_rdata valid; merge the store lane and issue the RAM write
// WR    | RAM write commits on this cycle's closing edge
// ACK   | one-cycle completion pulse, then back to IDLE unconditionally

module dmem_lsu #(
   parameter logic [31:0] BASE_ADDR   = 32'h10010000,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        fault,
   output logic        stall,
   output logic        ram_rena,
   output logic        ram_wena,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_MRG,
      S_WR,
      S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] rdata_d, ram_addr_d, ram_wdata_d;
   logic        ack_d, fault_d, ram_rena_d, ram_wena_d;
   logic        latch_en;

   logic        we_q, sext_q;
   logic [1:0]  size_q, lane_q;
   logic [15:0] wdata_q;

   logic [31:0] offset;
   logic        req_bad;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign stall = req & ~ack;

   // Subtraction is unsigned, so addresses below the base wrap to a huge offset and fault.
   assign offset  = addr - BASE_ADDR;
   assign req_bad = (size == 2'b11)
                 || (size == 2'b01 && addr[0])
                 || (size == 2'b10 && addr[1:0] != 2'b00)
                 || (offset >= RANGE_BYTES);

   always_comb begin
      byte_sel = ram_rdata[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (size_q)
         2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
         default: load_val = ram_rdata;
      endcase
   end

   always_comb begin
      merged = ram_rdata;
      if (size_q == 2'b00)
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata;
      ack_d       = 1'b0;
      fault_d     = fault;
      ram_rena_d  = 1'b0;
      ram_wena_d  = 1'b0;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      latch_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               latch_en = 1'b1;
               rdata_d  = 32'h0;
               if (req_bad) begin
                  fault_d = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_ACK;
               end else begin
                  fault_d    = 1'b0;
                  ram_addr_d = {addr[31:2], 2'b00};
                  if (we && size == 2'b10) begin
                     ram_wena_d  = 1'b1;
                     ram_wdata_d = wdata;
                     state_d     = S_WR;
                  end else begin
                     ram_rena_d = 1'b1;
                     state_d    = S_RD;
                  end
               end
            end
         end
         S_RD:  state_d = we_q ? S_MRG : S_CAP;
         S_CAP: begin
            rdata_d = load_val;
            ack_d   = 1'b1;
            state_d = S_ACK;
         end
         S_MRG: begin
            ram_wdata_d = merged;
            ram_wena_d  = 1'b1;
            state_d     = S_WR;
         end
         S_WR: begin
            ack_d   = 1'b1;
            state_d = S_ACK;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rdata     <= 32'h0;
         ack       <= 1'b0;
         fault     <= 1'b0;
         ram_rena  <= 1'b0;
         ram_wena  <= 1'b0;
         ram_addr  <= 32'h0;
         ram_wdata <= 32'h0;
      end else begin
         state_q   <= state_d;
         rdata     <= rdata_d;
         ack       <= ack_d;
         fault     <= fault_d;
         ram_rena  <= ram_rena_d;
         ram_wena  <= ram_wena_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= 2'b00;
         lane_q  <= 2'b00;
         wdata_q <= 16'h0;
      end else if (latch_en) begin
         we_q    <= we;
         sext_q  <= sext;
         size_q  <= size;
         lane_q  <= addr[1:0];
         wdata_q <= wdata[15:0];
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural sync-read/sync-write RAM.
// Expected values are hand-computed from the access sequence.

module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sext = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        ack, fault, stall, ram_rena, ram_wena;
   logic [31:0] ram_addr, ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:1023];
   int          rena_cnt = 0;
   int          wena_cnt = 0;
   int          both_cnt = 0;
   int          tests = 0;
   int          fails = 0;

   dmem_lsu dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .fault(fault),
      .stall(stall), .ram_rena(ram_rena), .ram_wena(ram_wena),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wena) mem[ram_addr[11:2]] <= ram_wdata;
      if (ram_rena) ram_rdata <= mem[ram_addr[11:2]];
      if (ram_rena) rena_cnt = rena_cnt + 1;
      if (ram_wena) wena_cnt = wena_cnt + 1;
      if (ram_rena && ram_wena) both_cnt = both_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one access from IDLE; request fields are scrambled after E0 to prove they are latched.
   task automatic access(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         output int edges, output logic [31:0] rd, output logic f,
                         output int dr, output int dw);
      int r0, w0;
      r0 = rena_cnt;
      w0 = wena_cnt;
      we = w; size = sz; sext = s; addr = a; wdata = d; req = 1'b1;
      #1;
      check("stall_while_req", {31'b0, stall}, 32'd1);
      edges = 0;
      while (edges < 20) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) begin
            we = ~w; size = ~sz; sext = ~s; addr = a ^ 32'h4; wdata = ~d;
         end
         if (ack) break;
      end
      rd = rdata;
      f  = fault;
      check("stall_in_ack", {31'b0, stall}, 32'd0);
      req = 1'b0;
      @(posedge clk); #1;
      dr = rena_cnt - r0;
      dw = wena_cnt - w0;
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
   } flt_t;

   initial begin
      int          e, dr, dw, n, r0, w0;
      logic [31:0] rd;
      logic        f;
      flt_t        flts [5];

      // reset state
      #12;
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_rena_wena", {30'b0, ram_rena, ram_wena}, 32'd0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // word store then load
      access(1'b1, 2'b10, 1'b0, 32'h10010004, 32'h11223344, e, rd, f, dr, dw);
      check("sw_latency", e, 32'd2);
      check("sw_enables", {dr[15:0], dw[15:0]}, {16'd0, 16'd1});
      check("sw_fault", {31'b0, f}, 32'd0);
      access(1'b0, 2'b10, 1'b1, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("lw_latency", e, 32'd3);
      check("lw_rdata", rd, 32'h11223344);
      check("lw_enables", {dr[15:0], dw[15:0]}, {16'd1, 16'd0});

      // byte store and loads
      access(1'b1, 2'b00, 1'b0, 32'h10010005, 32'h000000AA, e, rd, f, dr, dw);
      check("sb_latency", e, 32'd4);
      check("sb_enables", {dr[15:0], dw[15:0]}, {16'd1, 16'd1});
      access(1'b0, 2'b00, 1'b1, 32'h10010005, 32'h0, e, rd, f, dr, dw);
      check("lb_rdata", rd, 32'hFFFFFFAA);
      access(1'b0, 2'b00, 1'b0, 32'h10010005, 32'h0, e, rd, f, dr, dw);
      check("lbu_rdata", rd, 32'h000000AA);
      access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("sb_word", rd, 32'h1122AA44);

      // half store and loads
      access(1'b1, 2'b01, 1'b0, 32'h10010006, 32'h00008001, e, rd, f, dr, dw);
      check("sh_latency", e, 32'd4);
      access(1'b0, 2'b01, 1'b1, 32'h10010006, 32'h0, e, rd, f, dr, dw);
      check("lh_rdata", rd, 32'hFFFF8001);
      access(1'b0, 2'b01, 1'b0, 32'h10010006, 32'h0, e, rd, f, dr, dw);
      check("lhu_rdata", rd, 32'h00008001);
      access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("sh_word", rd, 32'h8001AA44);
      access(1'b0, 2'b00, 1'b1, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("lb_lane0_pos", rd, 32'h00000044);
      access(1'b0, 2'b00, 1'b1, 32'h10010007, 32'h0, e, rd, f, dr, dw);
      check("lb_lane3_neg", rd, 32'hFFFFFF80);
      access(1'b0, 2'b01, 1'b1, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("lh_lane0_neg", rd, 32'hFFFFAA44);

      // last valid word
      access(1'b1, 2'b10, 1'b0, 32'h10010FFC, 32'hCAFEF00D, e, rd, f, dr, dw);
      check("sw_top_fault", {31'b0, f}, 32'd0);
      access(1'b0, 2'b10, 1'b0, 32'h10010FFC, 32'h0, e, rd, f, dr, dw);
      check("lw_top_rdata", rd, 32'hCAFEF00D);
      check("lw_top_fault", {31'b0, f}, 32'd0);

      // faults
      flts[0] = '{1'b0, 2'b10, 32'h10010002};
      flts[1] = '{1'b1, 2'b01, 32'h10010001};
      flts[2] = '{1'b0, 2'b10, 32'h10011000};
      flts[3] = '{1'b0, 2'b10, 32'h1000FFFC};
      flts[4] = '{1'b0, 2'b11, 32'h10010004};
      for (int i = 0; i < 5; i++) begin
         access(flts[i].w, flts[i].sz, 1'b1, flts[i].a, 32'hDEADBEEF, e, rd, f, dr, dw);
         check($sformatf("flt%0d_latency", i), e, 32'd1);
         check($sformatf("flt%0d_fault", i), {31'b0, f}, 32'd1);
         check($sformatf("flt%0d_rdata", i), rd, 32'h0);
         check($sformatf("flt%0d_enables", i), {dr[15:0], dw[15:0]}, 32'd0);
      end
      access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("fault_cleared", {31'b0, f}, 32'd0);
      check("after_fault_rdata", rd, 32'h8001AA44);

      // reset during MRG aborts the sub-word store
      we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h10010004; wdata = 32'h00000055; req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      w0 = wena_cnt;
      rst_n = 1'b0;
      #1;
      check("mrg_rst_ack_fault", {30'b0, ack, fault}, 32'd0);
      check("mrg_rst_rdata", rdata, 32'h0);
      check("mrg_rst_enables", {30'b0, ram_rena, ram_wena}, 32'd0);
      check("mrg_rst_ram_addr", ram_addr, 32'h0);
      check("mrg_rst_ram_wdata", ram_wdata, 32'h0);
      req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("mrg_rst_no_write", wena_cnt - w0, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      access(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, e, rd, f, dr, dw);
      check("mrg_rst_old_word", rd, 32'h8001AA44);

      // req dropped in ack cycle: no further activity
      r0 = rena_cnt;
      repeat (5) @(posedge clk);
      #1;
      check("drop_no_ack", {31'b0, ack}, 32'd0);
      check("drop_no_rena", rena_cnt - r0, 32'd0);

      // req held through ack: identical second access
      r0 = rena_cnt;
      we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10010004; req = 1'b1;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1; n++;
         if (ack) break;
      end
      check("held_first_latency", n, 32'd3);
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1; n++;
         if (ack) break;
      end
      check("held_second_gap", n, 32'd4);
      check("held_second_rdata", rdata, 32'h8001AA44);
      req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("held_two_reads", rena_cnt - r0, 32'd2);
      check("held_idle_ack", {31'b0, ack}, 32'd0);
      check("never_both_enables", both_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
